// File: rtl/alu_issue_pkg.sv
// Shared ALU control codes, opcode/funct constants and EX control bundle for the ID/EX issue stage.
package alu_issue_pkg;

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_ORI = 5'b00100;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b00111;
  localparam logic [4:0] ALU_NOR = 5'b01100;
  localparam logic [4:0] ALU_XOR = 5'b01101;
  localparam logic [4:0] ALU_SLL = 5'b10000;
  localparam logic [4:0] ALU_EQ  = 5'b10001;
  localparam logic [4:0] ALU_GTZ = 5'b10010;
  localparam logic [4:0] ALU_LEZ = 5'b10011;
  localparam logic [4:0] ALU_GEZ = 5'b10100;
  localparam logic [4:0] ALU_SRL = 5'b11000;
  localparam logic [4:0] ALU_SRA = 5'b11001;
  localparam logic [4:0] ALU_MUL = 5'b11111;

  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] OP_REGIMM   = 6'h01;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_BLEZ     = 6'h06;
  localparam logic [5:0] OP_BGTZ     = 6'h07;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SW       = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;
  localparam logic [5:0] F_MUL  = 6'h02;

  typedef enum logic [1:0] {IN1_RS, IN1_SHAMT, IN1_LUI16} in1_sel_e;
  typedef enum logic [1:0] {IN2_RT, IN2_SEXT, IN2_ZEXT} in2_sel_e;
  typedef enum logic [1:0] {DST_NONE, DST_RD, DST_RT} dst_sel_e;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       illegal;
    logic       sign;
    logic [4:0] alu_ctl;
  } ex_ctl_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational opcode/funct decode into ALU control, operand/destination selects and memory flags.
// ALU_ISSUE_MUL_EN: when defined, opcode 1C / funct 02 decodes to MUL; otherwise it is illegal.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [4:0] o_alu_ctl,
  output logic       o_sign,
  output in1_sel_e   o_in1_sel,
  output in2_sel_e   o_in2_sel,
  output dst_sel_e   o_dst_sel,
  output logic       o_reg_write,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_illegal
);

  always_comb begin
    o_alu_ctl   = ALU_AND;
    o_sign      = 1'b0;
    o_in1_sel   = IN1_RS;
    o_in2_sel   = IN2_RT;
    o_dst_sel   = DST_NONE;
    o_reg_write = 1'b0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_illegal   = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_dst_sel   = DST_RD;
        o_reg_write = 1'b1;
        case (i_funct)
          F_ADD:  begin o_alu_ctl = ALU_ADD; o_sign = 1'b1; end
          F_ADDU: o_alu_ctl = ALU_ADD;
          F_SUB, F_SUBU: o_alu_ctl = ALU_SUB;
          F_AND:  o_alu_ctl = ALU_AND;
          F_OR:   o_alu_ctl = ALU_OR;
          F_XOR:  o_alu_ctl = ALU_XOR;
          F_NOR:  o_alu_ctl = ALU_NOR;
          F_SLT:  begin o_alu_ctl = ALU_SLT; o_sign = 1'b1; end
          F_SLTU: o_alu_ctl = ALU_SLT;
          F_SLL:  begin o_alu_ctl = ALU_SLL; o_in1_sel = IN1_SHAMT; end
          F_SRL:  begin o_alu_ctl = ALU_SRL; o_in1_sel = IN1_SHAMT; end
          F_SRA:  begin o_alu_ctl = ALU_SRA; o_in1_sel = IN1_SHAMT; end
          F_JR: begin
            o_alu_ctl   = ALU_ADD;
            o_dst_sel   = DST_NONE;
            o_reg_write = 1'b0;
          end
          default: begin
            o_illegal   = 1'b1;
            o_dst_sel   = DST_NONE;
            o_reg_write = 1'b0;
          end
        endcase
      end
      OP_SPECIAL2: begin
`ifdef ALU_ISSUE_MUL_EN
        if (i_funct == F_MUL) begin
          o_alu_ctl   = ALU_MUL;
          o_dst_sel   = DST_RD;
          o_reg_write = 1'b1;
        end else begin
          o_illegal = 1'b1;
        end
`else
        o_illegal = 1'b1;
`endif
      end
      OP_ADDI, OP_ADDIU: begin
        o_alu_ctl = ALU_ADD; o_in2_sel = IN2_SEXT; o_dst_sel = DST_RT; o_reg_write = 1'b1;
      end
      OP_ANDI: begin
        o_alu_ctl = ALU_AND; o_in2_sel = IN2_ZEXT; o_dst_sel = DST_RT; o_reg_write = 1'b1;
      end
      OP_ORI: begin
        o_alu_ctl = ALU_ORI; o_in2_sel = IN2_ZEXT; o_dst_sel = DST_RT; o_reg_write = 1'b1;
      end
      OP_XORI: begin
        o_alu_ctl = ALU_XOR; o_in2_sel = IN2_ZEXT; o_dst_sel = DST_RT; o_reg_write = 1'b1;
      end
      OP_SLTI, OP_SLTIU: begin
        o_alu_ctl   = ALU_SLT;
        o_sign      = (i_opcode == OP_SLTI);
        o_in2_sel   = IN2_SEXT;
        o_dst_sel   = DST_RT;
        o_reg_write = 1'b1;
      end
      // lui is a left shift of the zero-extended immediate by a constant 16
      OP_LUI: begin
        o_alu_ctl = ALU_SLL; o_in1_sel = IN1_LUI16; o_in2_sel = IN2_ZEXT;
        o_dst_sel = DST_RT;  o_reg_write = 1'b1;
      end
      OP_LW: begin
        o_alu_ctl = ALU_ADD; o_in2_sel = IN2_SEXT; o_dst_sel = DST_RT;
        o_reg_write = 1'b1;  o_mem_read = 1'b1;
      end
      OP_SW: begin
        o_alu_ctl = ALU_ADD; o_in2_sel = IN2_SEXT; o_mem_write = 1'b1;
      end
      OP_BEQ:    o_alu_ctl = ALU_SUB;
      OP_BNE:    o_alu_ctl = ALU_EQ;
      OP_BLEZ:   o_alu_ctl = ALU_GTZ;
      OP_BGTZ:   o_alu_ctl = ALU_LEZ;
      OP_REGIMM: o_alu_ctl = ALU_GEZ;
      default:   o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decode, operand select/extend, one-cycle EX register, MEM/WB forwarding onto
// the EX operands and load-use stall request. MUL decode is optional via ALU_ISSUE_MUL_EN.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [5:0]         id_opcode,
  input  logic [5:0]         id_funct,
  input  logic [4:0]         id_shamt,
  input  logic [15:0]        id_imm,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic [XLEN-1:0]    id_rs_data,
  input  logic [XLEN-1:0]    id_rt_data,
  input  logic               flush,
  input  logic               mem_reg_write,
  input  logic               wb_reg_write,
  input  logic [RADDR_W-1:0] mem_dst,
  input  logic [RADDR_W-1:0] wb_dst,
  input  logic [XLEN-1:0]    mem_result,
  input  logic [XLEN-1:0]    wb_result,
  output logic [XLEN-1:0]    ex_in1,
  output logic [XLEN-1:0]    ex_in2,
  output logic [4:0]         ex_alu_ctl,
  output logic               ex_sign,
  output logic               ex_valid,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic [RADDR_W-1:0] ex_dst,
  output logic               ex_illegal,
  output logic               stall_req
);

  logic [4:0]         w_alu_ctl;
  logic               w_sign, w_dec_wr, w_mem_rd, w_mem_wr, w_ill;
  in1_sel_e           w_in1_sel;
  in2_sel_e           w_in2_sel;
  dst_sel_e           w_dst_sel;
  logic [RADDR_W-1:0] w_id_dst, w_src1, w_src2;
  logic [XLEN-1:0]    w_id_in1, w_id_in2;
  logic               w_stall;

  ex_ctl_t            w_nxt_ctl, r_ctl;
  logic [RADDR_W-1:0] w_nxt_dst, w_nxt_src1, w_nxt_src2, r_dst, r_src1, r_src2;
  logic [XLEN-1:0]    w_nxt_in1, w_nxt_in2, r_in1, r_in2;

  alu_issue_decode u_decode (
    .i_opcode    (id_opcode),
    .i_funct     (id_funct),
    .o_alu_ctl   (w_alu_ctl),
    .o_sign      (w_sign),
    .o_in1_sel   (w_in1_sel),
    .o_in2_sel   (w_in2_sel),
    .o_dst_sel   (w_dst_sel),
    .o_reg_write (w_dec_wr),
    .o_mem_read  (w_mem_rd),
    .o_mem_write (w_mem_wr),
    .o_illegal   (w_ill)
  );

  always_comb begin
    w_id_dst = '0;
    case (w_dst_sel)
      DST_RD:  w_id_dst = id_rd;
      DST_RT:  w_id_dst = id_rt;
      default: w_id_dst = '0;
    endcase
    w_id_in1 = id_rs_data;
    case (w_in1_sel)
      IN1_SHAMT: w_id_in1 = XLEN'(id_shamt);
      IN1_LUI16: w_id_in1 = XLEN'(16);
      default:   w_id_in1 = id_rs_data;
    endcase
    w_id_in2 = id_rt_data;
    case (w_in2_sel)
      IN2_SEXT: w_id_in2 = {{(XLEN-16){id_imm[15]}}, id_imm};
      IN2_ZEXT: w_id_in2 = {{(XLEN-16){1'b0}}, id_imm};
      default:  w_id_in2 = id_rt_data;
    endcase
    // Source address 0 marks an operand that must never be forwarded (imm, shamt, constant)
    w_src1 = (w_in1_sel == IN1_RS) ? id_rs : '0;
    w_src2 = (w_in2_sel == IN2_RT) ? id_rt : '0;
  end

  assign w_stall = id_valid & ~flush & r_ctl.valid & r_ctl.mem_read & (r_dst != '0) &
                   ((r_dst == id_rs) | (r_dst == id_rt));
  assign stall_req = w_stall;

  always_comb begin
    w_nxt_ctl  = '0;
    w_nxt_dst  = '0;
    w_nxt_src1 = '0;
    w_nxt_src2 = '0;
    w_nxt_in1  = '0;
    w_nxt_in2  = '0;
    if (id_valid && !flush && !w_stall) begin
      w_nxt_ctl.valid     = 1'b1;
      w_nxt_ctl.reg_write = w_dec_wr & (w_id_dst != '0);
      w_nxt_ctl.mem_read  = w_mem_rd;
      w_nxt_ctl.mem_write = w_mem_wr;
      w_nxt_ctl.illegal   = w_ill;
      w_nxt_ctl.sign      = w_sign;
      w_nxt_ctl.alu_ctl   = w_alu_ctl;
      w_nxt_dst           = w_id_dst;
      w_nxt_src1          = w_src1;
      w_nxt_src2          = w_src2;
      w_nxt_in1           = w_id_in1;
      w_nxt_in2           = w_id_in2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctl  <= '0;
      r_dst  <= '0;
      r_src1 <= '0;
      r_src2 <= '0;
      r_in1  <= '0;
      r_in2  <= '0;
    end else begin
      r_ctl  <= w_nxt_ctl;
      r_dst  <= w_nxt_dst;
      r_src1 <= w_nxt_src1;
      r_src2 <= w_nxt_src2;
      r_in1  <= w_nxt_in1;
      r_in2  <= w_nxt_in2;
    end
  end

  function automatic logic [XLEN-1:0] f_fwd(input logic [RADDR_W-1:0] src,
                                            input logic [XLEN-1:0]    val,
                                            input logic               m_we,
                                            input logic [RADDR_W-1:0] m_dst,
                                            input logic [XLEN-1:0]    m_res,
                                            input logic               w_we,
                                            input logic [RADDR_W-1:0] w_dst,
                                            input logic [XLEN-1:0]    w_res);
    if (src == '0)                   return val;
    else if (m_we && (m_dst == src)) return m_res;
    else if (w_we && (w_dst == src)) return w_res;
    else                             return val;
  endfunction

  assign ex_in1 = f_fwd(r_src1, r_in1, mem_reg_write, mem_dst, mem_result,
                        wb_reg_write, wb_dst, wb_result);
  assign ex_in2 = f_fwd(r_src2, r_in2, mem_reg_write, mem_dst, mem_result,
                        wb_reg_write, wb_dst, wb_result);

  assign ex_alu_ctl   = r_ctl.alu_ctl;
  assign ex_sign      = r_ctl.sign;
  assign ex_valid     = r_ctl.valid;
  assign ex_reg_write = r_ctl.reg_write;
  assign ex_mem_read  = r_ctl.mem_read;
  assign ex_mem_write = r_ctl.mem_write;
  assign ex_illegal   = r_ctl.illegal;
  assign ex_dst       = r_dst;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: decode table via scoreboard queue plus forwarding/stall/flush/reset
// sequences. MUL row expectation follows ALU_ISSUE_MUL_EN.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset, id_valid, flush, mem_reg_write, wb_reg_write;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_shamt, id_rs, id_rt, id_rd, mem_dst, wb_dst, ex_dst;
  logic [15:0] id_imm;
  logic [31:0] id_rs_data, id_rt_data, mem_result, wb_result, ex_in1, ex_in2;
  logic [4:0]  ex_alu_ctl;
  logic        ex_sign, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal, stall_req;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
    .id_shamt(id_shamt), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .flush(flush),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write), .mem_dst(mem_dst),
    .wb_dst(wb_dst), .mem_result(mem_result), .wb_result(wb_result), .ex_in1(ex_in1),
    .ex_in2(ex_in2), .ex_alu_ctl(ex_alu_ctl), .ex_sign(ex_sign), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_dst(ex_dst), .ex_illegal(ex_illegal), .stall_req(stall_req)
  );

  typedef struct {
    logic        vld;
    logic [5:0]  op, fn;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b;
    logic [4:0]  ctl;
    logic        sgn;
    logic [31:0] e1, e2;
    logic [4:0]  dst;
    logic        rw, mr, mw, ill, ev, chk_ops;
  } vec_t;

  typedef struct {
    logic [4:0]  ctl;
    logic        sgn;
    logic [31:0] e1, e2;
    logic [4:0]  dst;
    logic        rw, mr, mw, ill, ev, chk_ops;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_opcode = 0; id_funct = 0; id_shamt = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_rs_data = 0; id_rt_data = 0; flush = 0;
    mem_reg_write = 0; wb_reg_write = 0; mem_dst = 0; wb_dst = 0; mem_result = 0; wb_result = 0;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [15:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    id_valid = 1; id_opcode = op; id_funct = fn; id_shamt = sh; id_imm = imm;
    id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = a; id_rt_data = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", ex_valid, 0);   chk("rst ctl", ex_alu_ctl, 0);
    chk("rst in1", ex_in1, 0);       chk("rst in2", ex_in2, 0);
    chk("rst dst", ex_dst, 0);       chk("rst rw", ex_reg_write, 0);
    chk("rst stall", stall_req, 0);
    @(negedge clk) reset = 0;

    // vld op fn sh imm rs rt rd a b | ctl sgn e1 e2 dst rw mr mw ill ev chk_ops
    tbl.push_back('{1, 6'h00, 6'h20, 0, 16'h0, 1, 2, 3, 5, 7, 5'b00010, 1, 5, 7, 3, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h00, 6'h21, 0, 16'h0, 1, 2, 6, 1, 2, 5'b00010, 0, 1, 2, 6, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h00, 6'h22, 0, 16'h0, 1, 2, 7, 9, 4, 5'b00110, 0, 9, 4, 7, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h00, 6'h23, 0, 16'h0, 1, 2, 7, 9, 4, 5'b00110, 0, 9, 4, 7, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h00, 6'h24, 0, 16'h0, 1, 2, 7, 3, 6, 5'b00000, 0, 3, 6, 7, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h00, 6'h25, 0, 16'h0, 1, 2, 7, 3, 6, 5'b00001, 0, 3, 6, 7, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h00, 6'h26, 0, 16'h0, 1, 2, 7, 3, 6, 5'b01101, 0, 3, 6, 7, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h00, 6'h27, 0, 16'h0, 1, 2, 7, 3, 6, 5'b01100, 0, 3, 6, 7, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h00, 6'h2A, 0, 16'h0, 1, 2, 9, 3, 6, 5'b00111, 1, 3, 6, 9, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h00, 6'h2B, 0, 16'h0, 1, 2, 9, 3, 6, 5'b00111, 0, 3, 6, 9, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h00, 6'h00, 4, 16'h0, 0, 2, 8, 0, 1, 5'b10000, 0, 4, 1, 8, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h00, 6'h02, 31, 16'h0, 0, 2, 8, 0, 1, 5'b11000, 0, 31, 1, 8, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h00, 6'h03, 7, 16'h0, 0, 2, 8, 0, 32'h80000000, 5'b11001, 0, 7, 32'h80000000, 8, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h00, 6'h08, 0, 16'h0, 31, 0, 0, 32'h400, 0, 5'b00010, 0, 32'h400, 0, 0, 0, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h00, 6'h20, 0, 16'h0, 1, 2, 0, 5, 7, 5'b00010, 1, 5, 7, 0, 0, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h08, 6'h00, 0, 16'hFFFF, 1, 4, 0, 10, 0, 5'b00010, 0, 10, 32'hFFFFFFFF, 4, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h0D, 6'h00, 0, 16'hFFFF, 1, 4, 0, 10, 0, 5'b00100, 0, 10, 32'h0000FFFF, 4, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h0F, 6'h00, 0, 16'h1234, 0, 5, 0, 0, 0, 5'b10000, 0, 16, 32'h00001234, 5, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h0C, 6'h00, 0, 16'h8001, 1, 4, 0, 3, 0, 5'b00000, 0, 3, 32'h00008001, 4, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h0E, 6'h00, 0, 16'h8001, 1, 4, 0, 3, 0, 5'b01101, 0, 3, 32'h00008001, 4, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h0A, 6'h00, 0, 16'hFFFE, 1, 4, 0, 3, 0, 5'b00111, 1, 3, 32'hFFFFFFFE, 4, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h0B, 6'h00, 0, 16'h8000, 1, 4, 0, 3, 0, 5'b00111, 0, 3, 32'hFFFF8000, 4, 1, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h23, 6'h00, 0, 16'h0004, 1, 2, 0, 32'h100, 0, 5'b00010, 0, 32'h100, 4, 2, 1, 1, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h2B, 6'h00, 0, 16'h8000, 1, 3, 0, 32'h100, 0, 5'b00010, 0, 32'h100, 32'hFFFF8000, 0, 0, 0, 1, 0, 1, 1});
    tbl.push_back('{1, 6'h04, 6'h00, 0, 16'h0010, 1, 2, 0, 5, 7, 5'b00110, 0, 5, 7, 0, 0, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h05, 6'h00, 0, 16'h0010, 1, 2, 0, 5, 7, 5'b10001, 0, 5, 7, 0, 0, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h06, 6'h00, 0, 16'h0010, 1, 0, 0, 5, 0, 5'b10010, 0, 5, 0, 0, 0, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h07, 6'h00, 0, 16'h0010, 1, 0, 0, 5, 0, 5'b10011, 0, 5, 0, 0, 0, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h01, 6'h00, 0, 16'h0010, 1, 0, 0, 5, 0, 5'b10100, 0, 5, 0, 0, 0, 0, 0, 0, 1, 1});
    tbl.push_back('{1, 6'h3F, 6'h00, 0, 16'h0000, 1, 4, 5, 5, 7, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0});
    tbl.push_back('{1, 6'h00, 6'h3F, 0, 16'h0000, 1, 4, 5, 5, 7, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0});
`ifdef ALU_ISSUE_MUL_EN
    tbl.push_back('{1, 6'h1C, 6'h02, 0, 16'h0000, 1, 2, 9, 3, 4, 5'b11111, 0, 3, 4, 9, 1, 0, 0, 0, 1, 1});
`else
    tbl.push_back('{1, 6'h1C, 6'h02, 0, 16'h0000, 1, 2, 9, 3, 4, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0});
`endif
    tbl.push_back('{0, 6'h00, 6'h20, 0, 16'h0000, 1, 2, 3, 5, 7, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].op, tbl[i].fn, tbl[i].sh, tbl[i].imm, tbl[i].rs, tbl[i].rt, tbl[i].rd,
            tbl[i].a, tbl[i].b);
      id_valid = tbl[i].vld;
      sb.push_back('{tbl[i].ctl, tbl[i].sgn, tbl[i].e1, tbl[i].e2, tbl[i].dst, tbl[i].rw,
                     tbl[i].mr, tbl[i].mw, tbl[i].ill, tbl[i].ev, tbl[i].chk_ops});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("row%0d ctl", i), ex_alu_ctl, e.ctl);
      chk($sformatf("row%0d sign", i), ex_sign, e.sgn);
      chk($sformatf("row%0d dst", i), ex_dst, e.dst);
      chk($sformatf("row%0d rw", i), ex_reg_write, e.rw);
      chk($sformatf("row%0d mr", i), ex_mem_read, e.mr);
      chk($sformatf("row%0d mw", i), ex_mem_write, e.mw);
      chk($sformatf("row%0d ill", i), ex_illegal, e.ill);
      chk($sformatf("row%0d valid", i), ex_valid, e.ev);
      if (e.chk_ops) begin
        chk($sformatf("row%0d in1", i), ex_in1, e.e1);
        chk($sformatf("row%0d in2", i), ex_in2, e.e2);
      end
    end

    // Forwarding: MEM beats WB, WB beats register value, $0 and shamt never forwarded
    @(negedge clk) idle(); drive(6'h00, 6'h20, 0, 0, 2, 3, 4, 32'h11, 32'h22);
    @(posedge clk); #1;
    id_valid = 0;
    mem_reg_write = 1; mem_dst = 2; mem_result = 32'hAA;
    wb_reg_write = 1;  wb_dst = 2;  wb_result = 32'hBB;
    #1 chk("fwd mem in1", ex_in1, 32'hAA); chk("fwd mem in2", ex_in2, 32'h22);
    mem_reg_write = 0;
    #1 chk("fwd wb in1", ex_in1, 32'hBB);
    wb_dst = 3;
    #1 chk("fwd none in1", ex_in1, 32'h11); chk("fwd wb in2", ex_in2, 32'hBB);
    mem_reg_write = 1; mem_dst = 3;
    #1 chk("fwd mem in2", ex_in2, 32'hAA);
    @(negedge clk) idle(); drive(6'h00, 6'h20, 0, 0, 0, 0, 4, 32'h33, 32'h44);
    @(posedge clk); #1;
    id_valid = 0;
    mem_reg_write = 1; mem_dst = 0; mem_result = 32'hAA;
    wb_reg_write = 1;  wb_dst = 0;  wb_result = 32'hBB;
    #1 chk("fwd r0 in1", ex_in1, 32'h33); chk("fwd r0 in2", ex_in2, 32'h44);
    @(negedge clk) idle(); drive(6'h00, 6'h00, 5, 0, 6, 7, 8, 32'h55, 32'h1);
    @(posedge clk); #1;
    id_valid = 0;
    mem_reg_write = 1; mem_dst = 6; mem_result = 32'hAA;
    #1 chk("fwd shamt in1", ex_in1, 32'd5);

    // Load-use stall, flush priority over stall, and lw to $0 never stalls
    @(negedge clk) idle(); drive(6'h23, 6'h00, 0, 16'h0, 1, 2, 0, 32'h100, 0);
    @(posedge clk); #1;
    drive(6'h00, 6'h20, 0, 0, 2, 3, 4, 32'h5, 32'h6);
    #1 chk("lu stall", stall_req, 1);
    flush = 1;
    #1 chk("lu flush prio", stall_req, 0);
    flush = 0;
    #1 chk("lu stall again", stall_req, 1);
    @(posedge clk); #1;
    chk("lu bubble valid", ex_valid, 0); chk("lu bubble rw", ex_reg_write, 0);
    chk("lu bubble mr", ex_mem_read, 0); chk("lu stall clear", stall_req, 0);
    @(posedge clk); #1;
    chk("lu issue valid", ex_valid, 1); chk("lu issue ctl", ex_alu_ctl, 5'b00010);
    chk("lu issue dst", ex_dst, 4);
    @(negedge clk) drive(6'h23, 6'h00, 0, 16'h0, 1, 0, 0, 32'h100, 0);
    @(posedge clk); #1;
    drive(6'h00, 6'h20, 0, 0, 0, 3, 4, 32'h0, 32'h6);
    #1 chk("lu r0 no stall", stall_req, 0);

    // Flush concurrent with a valid beq
    @(negedge clk) idle(); drive(6'h04, 6'h00, 0, 16'h10, 1, 2, 0, 5, 5); flush = 1;
    @(posedge clk); #1;
    chk("flush valid", ex_valid, 0); chk("flush ctl", ex_alu_ctl, 0);
    chk("flush in1", ex_in1, 0);

    // Reset mid-stream clears everything on the next edge
    @(negedge clk) idle(); drive(6'h00, 6'h20, 0, 0, 1, 2, 3, 5, 7);
    @(posedge clk); #1;
    chk("pre-rst valid", ex_valid, 1);
    @(negedge clk) reset = 1; flush = 0;
    @(posedge clk); #1;
    chk("mid-rst valid", ex_valid, 0); chk("mid-rst ctl", ex_alu_ctl, 0);
    chk("mid-rst in1", ex_in1, 0);     chk("mid-rst in2", ex_in2, 0);
    chk("mid-rst dst", ex_dst, 0);     chk("mid-rst rw", ex_reg_write, 0);
    chk("mid-rst sign", ex_sign, 0);
    @(negedge clk) reset = 0; idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID/EX stage of the pipelined CPU; drives the EX-stage ALU from the opposite side of its interface. Decodes opcode/funct into the 5-bit ALU control code and Sign, selects and extends operands, and registers them. Forwards from MEM/WB to the EX operands and raises a load-use stall request toward IF/ID.

Parameters:
XLEN, 32, datapath width
RADDR_W, 5, register-address width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_opcode  in  6  instr[31:26]
id_funct  in  6  instr[5:0]
id_shamt  in  5  instr[10:6]
id_imm  in  16  instr[15:0]
id_rs, id_rt, id_rd  in  RADDR_W  register addresses
id_rs_data, id_rt_data  in  XLEN  register-file read data
flush  in  1  insert bubble into EX (branch/jump taken)
mem_reg_write, wb_reg_write  in  1  downstream write enables
mem_dst, wb_dst  in  RADDR_W  downstream destinations
mem_result, wb_result  in  XLEN  downstream results
ex_in1, ex_in2  out  XLEN  ALU operands (forwarded)
ex_alu_ctl  out  5  ALU control code
ex_sign  out  1  signed compare select
ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  EX control
ex_dst  out  RADDR_W  EX destination register
ex_illegal  out  1  undecodable instruction in EX
stall_req  out  1  load-use hazard; IF/ID must hold

Behaviour:
- Reset: all registered EX fields 0 (bubble: ctl 00000, valid/write/mem 0, dst 0). Reset wins over flush and stall.
- Latency: one cycle from ID inputs to registered EX fields; forwarding is combinational on the EX side.
- Per cycle: reset -> clear; else flush or stall_req -> load bubble; else id_valid -> load decode; else load bubble.
- stall_req = ex_valid & ex_mem_read & ex_dst!=0 & (ex_dst==id_rs | ex_dst==id_rt), gated by id_valid. Flush has priority over stall.
- ALU codes: AND 00000, OR 00001, ADD 00010, SUB 00110, SLT 00111, NOR 01100, XOR 01101, SLL 10000, SRL 11000, SRA 11001, MUL 11111, EQ 10001, ORI 00100, GTZ 10010, LEZ 10011, GEZ 10100.
- Shift operand convention: in1 carries the shift amount, in2 carries the shifted value.
- R-type (opcode 0x00), funct:
  - 20/21 -> ADD, Sign=1 for 20 only
  - 22/23 -> SUB
  - 24 AND, 25 OR, 26 XOR, 27 NOR
  - 2A -> SLT, Sign=1; 2B -> SLT, Sign=0
  - 00 SLL, 02 SRL, 03 SRA with in1 = zero-extended shamt
  - 08 jr -> ADD with reg_write=0
  - write to rd
- opcode 1C, funct 02 -> MUL, write rd.
- I-type, write rt:
  - 08/09 ADD, sign-extended imm
  - 0C AND, 0D ORI, 0E XOR, all zero-extended imm
  - 0A SLT Sign=1, 0B SLT Sign=0, both sign-extended imm
  - 0F lui -> SLL, in1=16, in2=zero-extended imm
  - 23 lw -> ADD sign-ext, mem_read
  - 2B sw -> ADD sign-ext, mem_write, no reg write
- Branches (no write; EX branches on ALU zero):
  - 04 beq -> SUB
  - 05 bne -> EQ
  - 06 blez -> GTZ
  - 07 bgtz -> LEZ
  - 01 bltz -> GEZ
- Other opcodes/functs: bubble controls (AND, no write, no mem) with ex_valid=1 and ex_illegal=1.
- A destination of 0 forces reg_write=0.
- Forwarding per register-sourced operand:
  - match mem_reg_write & mem_dst==src & src!=0 -> mem_result
  - else match wb -> wb_result
  - else the registered value
  - MEM beats WB. Immediates and shamt are never forwarded.

Optional Feature:
ALU_ISSUE_MUL_EN: when defined, opcode 1C/funct 02 decodes to MUL (11111). When undefined, it decodes as illegal (ex_illegal=1, no write), and code 11111 is never emitted.

Decomposition:
- Package alu_issue_pkg holds:
  - ALU control code localparams
  - opcode/funct constants
  - packed struct of EX control fields
- One sub-module alu_issue_decode: pure combinational opcode/funct -> ctl, Sign, imm-extend mode, dst select, mem/write flags, illegal.
- Pipeline register, forwarding and hazard logic stay in the top module.

Test Plan:
- add $3,$1,$2 with rs=5, rt=7 -> next cycle ex_alu_ctl=00010, ex_sign=1, in1=5, in2=7, ex_dst=3, ex_reg_write=1.
- addi rt=4, imm=FFFF, rs=10 -> in2=FFFFFFFF, ctl 00010; ori imm=FFFF -> in2=0000FFFF, ctl 00100; lui imm=1234 -> in1=16, in2=00001234, ctl 10000.
- Forwarding: EX src rs=2, mem_dst=2 result=AA, wb_dst=2 result=BB -> in1=AA; mem_reg_write=0 -> in1=BB; with src=0 -> no forward.
- lw $2 in EX, ID add using $2 -> stall_req=1, next EX is a bubble (valid=0), ID held; the following cycle stall_req=0.
- flush=1 concurrent with valid beq -> EX bubble; reset asserted mid-stream -> all outputs 0 next edge.
- Opcode 3F -> ex_illegal=1, reg_write=0; opcode 1C/funct 02 -> ctl 11111 with ALU_ISSUE_MUL_EN, illegal without it.
